// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: WIDTH-bit words in over valid/ready, one bit per clock out on dout,
// with a one-word holding register so consecutive words stream without a gap.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, hreg, hreg_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             hfull, hfull_n, acc, last;
  assign in_ready   = !hfull;
  assign acc        = in_valid && in_ready;
  assign last       = bcnt == BW'(WIDTH - 1);
  assign dout_valid = state == SHIFT;
  assign dout       = dout_valid && sreg[MSB_FIRST ? WIDTH-1 : 0];
  assign word_done  = dout_valid && last;
  assign busy       = dout_valid || hfull;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      hreg  <= '0;
      bcnt  <= '0;
      hfull <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      hreg  <= hreg_n;
      bcnt  <= bcnt_n;
      hfull <= hfull_n;
    end
  // On the last bit a held word has priority; otherwise a new word bypasses hreg.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    hreg_n  = hreg;
    bcnt_n  = bcnt;
    hfull_n = hfull;
    if (state == IDLE) begin
      if (acc) begin
        state_n = SHIFT;
        sreg_n  = in_data;
        bcnt_n  = '0;
      end
    end else if (!last) begin
      sreg_n = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      bcnt_n = bcnt + 1'b1;
      if (acc) begin
        hreg_n  = in_data;
        hfull_n = 1'b1;
      end
    end else if (hfull) begin
      sreg_n  = hreg;
      hfull_n = 1'b0;
      bcnt_n  = '0;
    end else if (in_valid) begin
      sreg_n = in_data;
      bcnt_n = '0;
    end else begin
      state_n = IDLE;
      sreg_n  = '0;
      bcnt_n  = '0;
    end
  end
endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`, which drives the detector's serial `din` input. A one-word holding register lets back-to-back words stream with no idle bit between them, so patterns that straddle word boundaries reach the detector intact.

## Interface

**Parameters**
- `WIDTH`, default 8: bits per input word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. Low clears all state immediately.
- `in_data`, input, WIDTH: word to serialize.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a word this cycle. Combinational: `in_ready` = holding register empty.
- `dout`, output, 1: serial bit to the detector's `din`. Registered.
- `dout_valid`, output, 1: `dout` carries a payload bit this cycle. Registered.
- `word_done`, output, 1: one-cycle pulse, coincident with the last bit of each word. Registered.
- `busy`, output, 1: shift register or holding register is occupied.

## Operation

**Storage**
- Shift register `sreg` (WIDTH bits).
- Bit counter `bcnt` (clog2(WIDTH) bits).
- Holding register `hreg` with flag `hfull`.

**FSM states**
- IDLE: `sreg` is empty. `dout`=0, `dout_valid`=0, `word_done`=0.
- SHIFT: one bit is presented per cycle. `bcnt` counts 0..WIDTH-1.

**Transitions**
- IDLE to SHIFT: on `in_valid` && `in_ready`. The word loads directly into `sreg` (it bypasses `hreg`) and `bcnt` is set to 0.
- In SHIFT with `bcnt` < WIDTH-1: advance one bit and increment `bcnt`. If `in_valid` && `in_ready`, capture the word into `hreg` and set `hfull`=1.
- In SHIFT with `bcnt` == WIDTH-1 (last-bit cycle), evaluated at the next edge:
  - If `hfull`: load `sreg` from `hreg`, clear `hfull`, set `bcnt`=0, stay in SHIFT.
  - Else if `in_valid` (so `in_ready`=1): load `sreg` directly from `in_data`, set `bcnt`=0, stay in SHIFT.
  - Else: go to IDLE.
- When `hfull`=1 and `hreg` moves into `sreg` at an edge, `in_ready` is 0 during that cycle, so no new word is accepted at that edge. `hreg` accepts again from the following cycle.

**Bit order**
- `MSB_FIRST`=1: `dout` = `sreg`[WIDTH-1], shift left.
- `MSB_FIRST`=0: `dout` = `sreg`[0], shift right.

**Data integrity**
- Accepted words are never dropped or reordered.
- `in_data` is sampled only on an accepted edge.

**Reset**
- `reset`=0 at any time, including mid-word, asynchronously forces IDLE.
- Reset clears `sreg`, `hreg`, `hfull` and `bcnt`.
- Reset outputs: `dout`=0, `dout_valid`=0, `word_done`=0, `busy`=0, `in_ready`=1.
- A partially shifted word and any held word are discarded.

## Timing

- **Latency:** a word accepted at edge k presents its first bit on `dout`/`dout_valid` from edge k (cycle k+1). The last bit is in cycle k+WIDTH.
- **Throughput:** one bit per clock, sustained, while `in_valid` keeps up. Continuous streaming gives zero bubble cycles between words.
- **Backpressure:** `in_ready` is 0 only while `hfull`=1. `in_valid` may be held high across stall cycles.
- **`word_done`:** high exactly in each cycle where `bcnt`==WIDTH-1 and `dout_valid`=1.
- **`busy`:** 1 from the accept edge until the edge after the last bit of the final word. `busy` = `dout_valid` || `hfull`.
- **Idle filler:** while idle, `dout` is held at 0. Downstream detection therefore sees 0s between bursts.

## Test plan

1. **Reset release:** reset deasserted, `in_valid`=0 for 5 cycles → `dout`=0, `dout_valid`=0, `word_done`=0, `busy`=0, `in_ready`=1 throughout.
2. **Single word, MSB first:** `in_data`=8'b1001_0110 accepted at edge 0 → `dout` = 1,0,0,1,0,1,1,0 in cycles 1–8; `dout_valid`=1 for exactly 8 cycles; `word_done` high only in cycle 8; IDLE in cycle 9.
3. **Back-to-back words:** 8'hA5 then 8'h3C, with `in_valid` held high → 16 contiguous valid bits 1010_0101_0011_1100. `in_ready` drops the cycle after the second accept and stays low until the `hreg`→`sreg` transfer edge has passed. `word_done` pulses in cycles 8 and 16.
4. **Backpressure:** three words offered continuously → the third is held off while `hfull`=1 and accepted once `in_ready` returns. Output is 24 contiguous bits in order, with none lost or duplicated.
5. **LSB first:** `MSB_FIRST`=0, `in_data`=8'b0000_1001 → `dout` = 1,0,0,1,0,0,0,0 in cycles 1–8.
6. **Reset mid-word:** `reset` pulsed low in cycle 4 of a word, with a second word held → outputs clear immediately without waiting for a clock edge. After release the block is IDLE with `in_ready`=1, and no residual bits appear.
